// File: rtl/display_scheduler.sv
// Display sequencer for the 8-digit result display: rate-limits measurement updates,
// saturates shown values, arbitrates with a status-message requester and blanks on timeout.
module display_scheduler #(
    parameter int unsigned HOLD_CYCLES    = 102400,
    parameter int unsigned TIMEOUT_CYCLES = 1024000,
    parameter int unsigned LIMIT          = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       meas_valid,
    input  logic [9:0] meas_cents,
    input  logic [2:0] meas_note,
    input  logic       msg_req,
    input  logic [9:0] msg_value,
    input  logic [2:0] msg_code,
    output logic       msg_grant,
    output logic [9:0] num_to_display,
    output logic [2:0] note,
    output logic       upd_strobe,
    output logic       stale
);

    localparam int unsigned    CW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX    = '1;
    localparam logic [2:0]     NOTE_BLANK = 3'h7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_SHOW,
        S_MSG
    } state_t;

    state_t        state_q;
    logic [CW-1:0] hold_q;
    logic [CW-1:0] tmo_q;
    logic          pend_q;
    logic [9:0]    pval_q;
    logic [2:0]    pnote_q;
    logic [9:0]    num_q;
    logic [2:0]    note_q;
    logic          strobe_q;
    logic          grant_q;
    logic          stale_q;

    logic [9:0]    meas_sat;
    logic [9:0]    pend_sat;
    logic [9:0]    msg_sat;

    function automatic logic [9:0] sat(input logic [9:0] v);
        int sv;
        sv = int'($signed(v));
        if (sv > int'(LIMIT))
            return 10'(LIMIT);
        else if (sv < -int'(LIMIT))
            return 10'(-int'(LIMIT));
        return v;
    endfunction

    always_comb begin
        meas_sat = sat(meas_cents);
        pend_sat = sat(pval_q);
        msg_sat  = sat(msg_value);
    end

    // Buffer writes happen by default whenever meas_valid is seen; a direct apply
    // overrides pend_q afterwards, and a buffer apply leaves pend_q = meas_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            tmo_q    <= '0;
            pend_q   <= 1'b0;
            pval_q   <= '0;
            pnote_q  <= '0;
            num_q    <= '0;
            note_q   <= NOTE_BLANK;
            strobe_q <= 1'b0;
            grant_q  <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (tmo_q != CNT_MAX)
                tmo_q <= tmo_q + 1'b1;
            if (meas_valid) begin
                pend_q  <= 1'b1;
                pval_q  <= meas_cents;
                pnote_q <= meas_note;
            end

            case (state_q)
                S_IDLE, S_SHOW: begin
                    if (msg_req) begin
                        num_q    <= msg_sat;
                        note_q   <= msg_code;
                        grant_q  <= 1'b1;
                        strobe_q <= 1'b1;
                        stale_q  <= 1'b0;
                        state_q  <= S_MSG;
                    end else if (meas_valid) begin
                        num_q    <= meas_sat;
                        note_q   <= meas_note;
                        strobe_q <= 1'b1;
                        stale_q  <= 1'b0;
                        pend_q   <= 1'b0;
                        tmo_q    <= '0;
                        hold_q   <= '0;
                        state_q  <= S_HOLD;
                    end else if (pend_q) begin
                        num_q    <= pend_sat;
                        note_q   <= pnote_q;
                        strobe_q <= 1'b1;
                        stale_q  <= 1'b0;
                        pend_q   <= 1'b0;
                        tmo_q    <= '0;
                        hold_q   <= '0;
                        state_q  <= S_HOLD;
                    end else if (state_q == S_SHOW && tmo_q >= TMO_LAST) begin
                        num_q    <= '0;
                        note_q   <= NOTE_BLANK;
                        strobe_q <= 1'b1;
                        stale_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        if (msg_req) begin
                            num_q    <= msg_sat;
                            note_q   <= msg_code;
                            grant_q  <= 1'b1;
                            strobe_q <= 1'b1;
                            stale_q  <= 1'b0;
                            state_q  <= S_MSG;
                        end else if (pend_q) begin
                            num_q    <= pend_sat;
                            note_q   <= pnote_q;
                            strobe_q <= 1'b1;
                            stale_q  <= 1'b0;
                            pend_q   <= meas_valid;
                            tmo_q    <= '0;
                            hold_q   <= '0;
                        end else begin
                            state_q <= S_SHOW;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_MSG: begin
                    if (msg_req) begin
                        if (msg_sat != num_q || msg_code != note_q) begin
                            num_q    <= msg_sat;
                            note_q   <= msg_code;
                            strobe_q <= 1'b1;
                        end
                    end else begin
                        grant_q  <= 1'b0;
                        strobe_q <= 1'b1;
                        if (pend_q) begin
                            num_q   <= pend_sat;
                            note_q  <= pnote_q;
                            stale_q <= 1'b0;
                            pend_q  <= meas_valid;
                            tmo_q   <= '0;
                            hold_q  <= '0;
                            state_q <= S_HOLD;
                        end else begin
                            num_q   <= '0;
                            note_q  <= NOTE_BLANK;
                            stale_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign msg_grant      = grant_q;
    assign num_to_display = num_q;
    assign note           = note_q;
    assign upd_strobe     = strobe_q;
    assign stale          = stale_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with HOLD_CYCLES=8, TIMEOUT_CYCLES=32, LIMIT=99.
module tb_display_scheduler;

    logic       clk;
    logic       rst_n;
    logic       meas_valid;
    logic [9:0] meas_cents;
    logic [2:0] meas_note;
    logic       msg_req;
    logic [9:0] msg_value;
    logic [2:0] msg_code;
    logic       msg_grant;
    logic [9:0] num_to_display;
    logic [2:0] note;
    logic       upd_strobe;
    logic       stale;

    int vectors = 0;
    int errors  = 0;

    display_scheduler #(
        .HOLD_CYCLES(8),
        .TIMEOUT_CYCLES(32),
        .LIMIT(99)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .meas_valid(meas_valid),
        .meas_cents(meas_cents),
        .meas_note(meas_note),
        .msg_req(msg_req),
        .msg_value(msg_value),
        .msg_code(msg_code),
        .msg_grant(msg_grant),
        .num_to_display(num_to_display),
        .note(note),
        .upd_strobe(upd_strobe),
        .stale(stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        meas_valid = 1'b0;
        meas_cents = '0;
        meas_note  = '0;
        msg_req    = 1'b0;
        msg_value  = '0;
        msg_code   = '0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({num_to_display, note, msg_grant, upd_strobe, stale} !== {10'd0, 3'h7, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got num=%0d note=%0d grant=%b strobe=%b stale=%b, want 0/7/0/0/0",
                     $signed(num_to_display), note, msg_grant, upd_strobe, stale);
        end
        meas_valid = 1'b1; meas_cents = 10'd5; meas_note = 3'd2;
        tick();
        meas_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({num_to_display, note, msg_grant, upd_strobe, stale} !== {10'd0, 3'h7, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_hold: got num=%0d note=%0d grant=%b strobe=%b stale=%b, want 0/7/0/0/0",
                     $signed(num_to_display), note, msg_grant, upd_strobe, stale);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (upd_strobe !== 1'b0 || note !== 3'h7) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: got strobe=%b note=%0d, want 0/7", i, upd_strobe, note);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        meas_valid = 1'b1; meas_cents = 10'(-37); meas_note = 3'd3;
        tick();
        meas_valid = 1'b0;
        vectors++;
        if (num_to_display !== 10'(-37) || note !== 3'd3 || upd_strobe !== 1'b1 || stale !== 1'b0) begin
            errors++;
            $display("FAIL single_apply: got num=%0d note=%0d strobe=%b stale=%b, want -37/3/1/0",
                     $signed(num_to_display), note, upd_strobe, stale);
        end
        for (int i = 1; i < 32; i++) begin
            tick();
            vectors++;
            if (num_to_display !== 10'(-37) || note !== 3'd3 || upd_strobe !== 1'b0) begin
                errors++;
                $display("FAIL single_hold cyc %0d: got num=%0d note=%0d strobe=%b, want -37/3/0",
                         i, $signed(num_to_display), note, upd_strobe);
            end
        end
        tick();
        vectors++;
        if (num_to_display !== 10'd0 || note !== 3'h7 || upd_strobe !== 1'b1 || stale !== 1'b1) begin
            errors++;
            $display("FAIL timeout_blank: got num=%0d note=%0d strobe=%b stale=%b, want 0/7/1/1",
                     $signed(num_to_display), note, upd_strobe, stale);
        end
        tick();
        vectors++;
        if (upd_strobe !== 1'b0 || stale !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: got strobe=%b stale=%b, want 0/1", upd_strobe, stale);
        end
        meas_valid = 1'b1; meas_cents = 10'd12; meas_note = 3'd6;
        tick();
        meas_valid = 1'b0;
        vectors++;
        if (num_to_display !== 10'd12 || note !== 3'd6 || stale !== 1'b0 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL stale_clear: got num=%0d note=%0d stale=%b strobe=%b, want 12/6/0/1",
                     $signed(num_to_display), note, stale, upd_strobe);
        end
    endtask

    task automatic test_burst();
        do_reset();
        meas_valid = 1'b1; meas_cents = 10'd10; meas_note = 3'd1;
        tick();
        meas_valid = 1'b0;
        vectors++;
        if (num_to_display !== 10'd10 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL burst_first: got num=%0d strobe=%b, want 10/1", $signed(num_to_display), upd_strobe);
        end
        for (int c = 1; c < 8; c++) begin
            meas_valid = (c == 2 || c == 5);
            meas_cents = (c == 2) ? 10'd20 : 10'd30;
            tick();
            meas_valid = 1'b0;
            vectors++;
            if (num_to_display !== 10'd10 || upd_strobe !== 1'b0) begin
                errors++;
                $display("FAIL burst_hold cyc %0d: got num=%0d strobe=%b, want 10/0",
                         c, $signed(num_to_display), upd_strobe);
            end
        end
        tick();
        vectors++;
        if (num_to_display !== 10'd30 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL burst_latest: got num=%0d strobe=%b, want 30/1", $signed(num_to_display), upd_strobe);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (num_to_display !== 10'd30 || upd_strobe !== 1'b0) begin
                errors++;
                $display("FAIL burst_no20 cyc %0d: got num=%0d strobe=%b, want 30/0",
                         c, $signed(num_to_display), upd_strobe);
            end
        end
    endtask

    task automatic test_saturation();
        logic [9:0] in_v  [5];
        logic [9:0] exp_v [5];
        in_v[0] = 10'd300;     exp_v[0] = 10'd99;
        in_v[1] = 10'(-512);   exp_v[1] = 10'(-99);
        in_v[2] = 10'd99;      exp_v[2] = 10'd99;
        in_v[3] = 10'(-99);    exp_v[3] = 10'(-99);
        in_v[4] = 10'd100;     exp_v[4] = 10'd99;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            meas_valid = 1'b1; meas_cents = in_v[i]; meas_note = 3'd0;
            tick();
            meas_valid = 1'b0;
            vectors++;
            if (num_to_display !== exp_v[i]) begin
                errors++;
                $display("FAIL saturation in=%0d: got %0d, want %0d",
                         $signed(in_v[i]), $signed(num_to_display), $signed(exp_v[i]));
            end
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        meas_valid = 1'b1; meas_cents = 10'd15; meas_note = 3'd2;
        tick();
        meas_valid = 1'b0;
        tick(); tick();
        msg_req = 1'b1; msg_value = 10'd0; msg_code = 3'd5;
        for (int c = 3; c < 8; c++) begin
            tick();
            vectors++;
            if (msg_grant !== 1'b0 || num_to_display !== 10'd15) begin
                errors++;
                $display("FAIL arb_wait cyc %0d: got grant=%b num=%0d, want 0/15",
                         c, msg_grant, $signed(num_to_display));
            end
        end
        tick();
        vectors++;
        if (msg_grant !== 1'b1 || num_to_display !== 10'd0 || note !== 3'd5 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL arb_grant: got grant=%b num=%0d note=%0d strobe=%b, want 1/0/5/1",
                     msg_grant, $signed(num_to_display), note, upd_strobe);
        end
        meas_valid = 1'b1; meas_cents = 10'd44; meas_note = 3'd4;
        tick();
        meas_valid = 1'b0;
        vectors++;
        if (msg_grant !== 1'b1 || num_to_display !== 10'd0 || note !== 3'd5 || upd_strobe !== 1'b0) begin
            errors++;
            $display("FAIL arb_msg_kept: got grant=%b num=%0d note=%0d strobe=%b, want 1/0/5/0",
                     msg_grant, $signed(num_to_display), note, upd_strobe);
        end
        msg_value = 10'd200;
        tick();
        vectors++;
        if (num_to_display !== 10'd99 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL arb_msg_track: got num=%0d strobe=%b, want 99/1", $signed(num_to_display), upd_strobe);
        end
        tick();
        vectors++;
        if (upd_strobe !== 1'b0) begin
            errors++;
            $display("FAIL arb_msg_steady: got strobe=%b, want 0", upd_strobe);
        end
        msg_req = 1'b0;
        tick();
        vectors++;
        if (msg_grant !== 1'b0 || num_to_display !== 10'd44 || note !== 3'd4 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL arb_release: got grant=%b num=%0d note=%0d strobe=%b, want 0/44/4/1",
                     msg_grant, $signed(num_to_display), note, upd_strobe);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        meas_valid = 1'b1; meas_cents = 10'd7; meas_note = 3'd1;
        msg_req = 1'b1; msg_value = 10'(-3); msg_code = 3'd4;
        tick();
        meas_valid = 1'b0;
        vectors++;
        if (msg_grant !== 1'b1 || num_to_display !== 10'(-3) || note !== 3'd4) begin
            errors++;
            $display("FAIL simul_msg_wins: got grant=%b num=%0d note=%0d, want 1/-3/4",
                     msg_grant, $signed(num_to_display), note);
        end
        tick();
        msg_req = 1'b0;
        tick();
        vectors++;
        if (msg_grant !== 1'b0 || num_to_display !== 10'd7 || note !== 3'd1 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL simul_release: got grant=%b num=%0d note=%0d strobe=%b, want 0/7/1/1",
                     msg_grant, $signed(num_to_display), note, upd_strobe);
        end
        meas_valid = 1'b1; meas_cents = 10'd9;
        tick();
        meas_valid = 1'b0;
        for (int c = 2; c < 8; c++) tick();
        vectors++;
        if (num_to_display !== 10'd7) begin
            errors++;
            $display("FAIL simul_hold: got num=%0d, want 7", $signed(num_to_display));
        end
        tick();
        vectors++;
        if (num_to_display !== 10'd9 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL simul_next: got num=%0d strobe=%b, want 9/1", $signed(num_to_display), upd_strobe);
        end
    endtask

    task automatic test_msg_blank();
        do_reset();
        msg_req = 1'b1; msg_value = 10'd33; msg_code = 3'd0;
        tick();
        msg_req = 1'b0;
        tick();
        vectors++;
        if (msg_grant !== 1'b0 || num_to_display !== 10'd0 || note !== 3'h7 || stale !== 1'b0 || upd_strobe !== 1'b1) begin
            errors++;
            $display("FAIL msg_blank: got grant=%b num=%0d note=%0d stale=%b strobe=%b, want 0/0/7/0/1",
                     msg_grant, $signed(num_to_display), note, stale, upd_strobe);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_saturation();
        test_arbitration();
        test_simultaneous();
        test_msg_blank();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
